// File: rtl/nunchuck_responder.sv
// nunchuck_responder
//   I2C target that emulates a Wii Nunchuck. It lets scripted joystick,
//   accelerometer and button values be read by an I2C initiator.
//   SDA is open-drain and is only ever pulled low or released. SCL is an
//   input only, so the target never stretches the clock. Both lines are
//   oversampled on clk, which must run at 20x SCL or faster.
//
//   Optional build macro: NUNCHUCK_INIT_CHECK_EN
//     defined   -> every read byte returns 8'hFF until init_done is set
//     undefined -> data is returned regardless of init_done
//
// Ports
//   clk        system clock
//   rst        synchronous active-low reset
//   scl        I2C clock from the initiator
//   sda        I2C data (inout, driven 0 or 'z)
//   stick_x/y  joystick values, bytes 0 and 1
//   accel_x/y/z 10-bit accelerometer values
//   z, c       buttons, 1 = pressed (sent active-low)
//   busy       high from a matched address until STOP
//   init_done  high once 8'h55 -> reg 8'hF0 and 8'h00 -> reg 8'hFB are seen
module nunchuck_responder #(
  parameter logic [6:0] I2C_ADDR  = 7'h52,
  parameter int         NUM_BYTES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] stick_x,
  input  logic [7:0] stick_y,
  input  logic [9:0] accel_x,
  input  logic [9:0] accel_y,
  input  logic [9:0] accel_z,
  input  logic       z,
  input  logic       c,
  output logic       busy,
  output logic       init_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_BYTE  = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6
  } state_t;

  state_t      state_r;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  rx_r;
  logic [7:0]  tx_r;
  logic        sda_oe_r;
  logic        busy_r;
  logic        init_done_r;
  logic        f0_seen_r;
  logic        fb_seen_r;
  logic        first_byte_r;
  logic [7:0]  pointer_r;
  logic [47:0] shadow_r;

  logic scl_meta_r, scl_sync_r, scl_hist_r;
  logic sda_meta_r, sda_sync_r, sda_hist_r;

  logic        scl_rise_s, scl_fall_s, start_s, stop_s;
  logic        data_gate_s;
  logic [47:0] live_frame_s;
  logic [7:0]  first_rd_s;
  logic [7:0]  next_rd_s;

  // Pick one frame byte by pointer; out-of-range pointers and a closed gate read 8'hFF.
  function automatic logic [7:0] load_byte(input logic [47:0] frame,
                                           input logic [7:0]  ptr,
                                           input logic        gate);
    logic [7:0] b;
    b = 8'hFF;
    if ({24'd0, ptr} >= 32'(NUM_BYTES)) begin
      b = 8'hFF;
    end else begin
      case (ptr)
        8'd0:    b = frame[7:0];
        8'd1:    b = frame[15:8];
        8'd2:    b = frame[23:16];
        8'd3:    b = frame[31:24];
        8'd4:    b = frame[39:32];
        8'd5:    b = frame[47:40];
        default: b = 8'hFF;
      endcase
    end
    if (!gate) begin
      b = 8'hFF;
    end else begin
      b = b;
    end
    return b;
  endfunction

`ifdef NUNCHUCK_INIT_CHECK_EN
  assign data_gate_s = init_done_r;
`else
  assign data_gate_s = 1'b1;
`endif

  // Byte 0 sits in the low bits; byte 5 packs the accelerometer LSBs and the buttons (active-low).
  assign live_frame_s = {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z,
                         accel_z[9:2], accel_y[9:2], accel_x[9:2],
                         stick_y, stick_x};

  // The first read byte comes straight from the live inputs, since the shadow loads on the same edge.
  assign first_rd_s = load_byte(live_frame_s, pointer_r, data_gate_s);
  assign next_rd_s  = load_byte(shadow_r, pointer_r + 8'd1, data_gate_s);

  assign scl_rise_s = scl_sync_r & ~scl_hist_r;
  assign scl_fall_s = ~scl_sync_r & scl_hist_r;
  assign start_s    = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
  assign stop_s     = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;

  assign sda       = sda_oe_r ? 1'b0 : 1'bz;
  assign busy      = busy_r;
  assign init_done = init_done_r;

  // Two-flop synchronizers plus a history flop for edge detection on SCL and SDA.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_hist_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_meta_r <= scl;
      scl_sync_r <= scl_meta_r;
      scl_hist_r <= scl_sync_r;
      sda_meta_r <= sda;
      sda_sync_r <= sda_meta_r;
      sda_hist_r <= sda_sync_r;
    end
  end

  // Protocol FSM: START/STOP override every state; data sampled on SCL rise, SDA changed on SCL fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 4'd0;
      rx_r         <= 8'd0;
      tx_r         <= 8'hFF;
      sda_oe_r     <= 1'b0;
      busy_r       <= 1'b0;
      init_done_r  <= 1'b0;
      f0_seen_r    <= 1'b0;
      fb_seen_r    <= 1'b0;
      first_byte_r <= 1'b0;
      pointer_r    <= 8'd0;
      shadow_r     <= 48'd0;
    end else begin
      init_done_r <= f0_seen_r & fb_seen_r;
      if (start_s) begin
        state_r   <= ADDR;
        bit_cnt_r <= 4'd0;
        sda_oe_r  <= 1'b0;
      end else if (stop_s) begin
        state_r  <= IDLE;
        busy_r   <= 1'b0;
        sda_oe_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            sda_oe_r <= 1'b0;
          end
          ADDR: begin
            if (scl_rise_s && bit_cnt_r != 4'd8) begin
              rx_r      <= {rx_r[6:0], sda_sync_r};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
              if (rx_r[7:1] == I2C_ADDR) begin
                sda_oe_r <= 1'b1;
                busy_r   <= 1'b1;
                state_r  <= ADDR_ACK;
              end else begin
                state_r <= IDLE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall_s) begin
              if (rx_r[0]) begin
                // Snapshot once per read so the frame cannot tear mid-transfer.
                shadow_r  <= live_frame_s;
                tx_r      <= {first_rd_s[6:0], 1'b1};
                sda_oe_r  <= ~first_rd_s[7];
                bit_cnt_r <= 4'd1;
                state_r   <= RD_BYTE;
              end else begin
                sda_oe_r     <= 1'b0;
                bit_cnt_r    <= 4'd0;
                first_byte_r <= 1'b1;
                state_r      <= WR_BYTE;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise_s && bit_cnt_r != 4'd8) begin
              rx_r      <= {rx_r[6:0], sda_sync_r};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
              sda_oe_r <= 1'b1;
              state_r  <= WR_ACK;
              if (first_byte_r) begin
                pointer_r    <= rx_r;
                first_byte_r <= 1'b0;
              end else begin
                // Only the two init registers are tracked; other writes are acknowledged and dropped.
                if (pointer_r == 8'hF0 && rx_r == 8'h55) begin
                  f0_seen_r <= 1'b1;
                end
                if (pointer_r == 8'hFB && rx_r == 8'h00) begin
                  fb_seen_r <= 1'b1;
                end
                pointer_r <= pointer_r + 8'd1;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall_s) begin
              sda_oe_r  <= 1'b0;
              bit_cnt_r <= 4'd0;
              state_r   <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_oe_r <= 1'b0;
                state_r  <= RD_ACK;
              end else begin
                sda_oe_r  <= ~tx_r[7];
                tx_r      <= {tx_r[6:0], 1'b1};
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise_s) begin
              pointer_r <= pointer_r + 8'd1;
              if (!sda_sync_r) begin
                // bit_cnt 0 means the MSB is driven on the coming fall.
                tx_r      <= next_rd_s;
                bit_cnt_r <= 4'd0;
                state_r   <= RD_BYTE;
              end else begin
                // Initiator NACK: busy is held until the STOP arrives.
                state_r <= IDLE;
              end
            end
          end
          default: begin
            state_r  <= IDLE;
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nunchuck_responder.sv
module tb_nunchuck_responder;

  localparam int Q = 100;  // quarter SCL period in ns (SCL = 20 clk)

  typedef struct {
    string       name;
    int unsigned val;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];
  int checks = 0;
  int errors = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] stick_x = 8'h80;
  logic [7:0] stick_y = 8'h7F;
  logic [9:0] accel_x = 10'h2A6;
  logic [9:0] accel_y = 10'h1FF;
  logic [9:0] accel_z = 10'h303;
  logic       z = 1'b1;
  logic       c = 1'b0;
  logic       busy;
  logic       init_done;
  wire        sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  nunchuck_responder dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .stick_x(stick_x), .stick_y(stick_y),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .z(z), .c(c), .busy(busy), .init_done(init_done)
  );

  always #10 clk = ~clk;

  // Scoreboard monitor: pairs each observation with the oldest expectation.
  initial begin
    item_t o;
    item_t e;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s: got 0x%0h with no expectation queued", o.name, o.val);
        end else begin
          e = exp_q.pop_front();
          if (o.val !== e.val || o.name != e.name) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (%s)", o.name, o.val, e.val, e.name);
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic expect_v(input string name, input int unsigned v);
    exp_q.push_back('{name, v});
  endtask

  task automatic observe(input string name, input int unsigned v);
    obs_q.push_back('{name, v});
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; #Q;
    scl = 1'b1;       #Q;
    m_sda_low = 1'b1; #Q;
    scl = 1'b0;       #Q;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; #Q;
    scl = 1'b1;       #Q;
    m_sda_low = 1'b0; #Q;
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; #Q;
    scl = 1'b1;     #(2*Q);
    scl = 1'b0;     #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; #Q;
    scl = 1'b1;       #Q;
    b = sda;          #Q;
    scl = 1'b0;       #Q;
  endtask

  // Send a byte and score the target's ACK (1 = ACK seen).
  task automatic send(input string name, input logic [7:0] d, input logic exp_ack);
    logic b;
    expect_v(name, {31'd0, exp_ack});
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    observe(name, {31'd0, ~b});
  endtask

  // Receive a byte, score it, then ACK (ack=1) or NACK.
  task automatic recv(input string name, input logic [7:0] exp_d, input logic ack);
    logic [7:0] d;
    logic b;
    expect_v(name, {24'd0, exp_d});
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack);
    observe(name, {24'd0, d});
  endtask

  task automatic set_ptr(input logic [7:0] p);
    i2c_start();
    send("ptr_addr_ack", 8'hA4, 1'b1);
    send("ptr_data_ack", p, 1'b1);
    i2c_stop();
  endtask

  task automatic check_sig(input string name, input logic actual, input logic req);
    expect_v(name, {31'd0, req});
    observe(name, {31'd0, actual});
  endtask

  initial begin
    logic [7:0] pre0, pre1, post_rst;

    // Reset state
    repeat (5) @(negedge clk);
    check_sig("rst_busy", busy, 1'b0);
    check_sig("rst_init_done", init_done, 1'b0);
    check_sig("rst_sda_released", sda, 1'b1);
    rst = 1'b1;
    repeat (5) @(negedge clk);

`ifdef NUNCHUCK_INIT_CHECK_EN
    pre0 = 8'hFF; pre1 = 8'hFF;
`else
    pre0 = 8'h80; pre1 = 8'h7F;
`endif
    // Read before init from pointer 0
    i2c_start();
    send("pre_addr_ack", 8'hA5, 1'b1);
    recv("pre_byte0", pre0, 1'b1);
    recv("pre_byte1", pre1, 1'b0);
    i2c_stop();

    // 1: init sequence
    i2c_start();
    send("init1_addr", 8'hA4, 1'b1);
    send("init1_reg", 8'hF0, 1'b1);
    send("init1_data", 8'h55, 1'b1);
    i2c_stop();
    check_sig("init_after_f0", init_done, 1'b0);
    i2c_start();
    send("init2_addr", 8'hA4, 1'b1);
    send("init2_reg", 8'hFB, 1'b1);
    send("init2_data", 8'h00, 1'b1);
    i2c_stop();
    check_sig("init_done", init_done, 1'b1);
    check_sig("init_busy", busy, 1'b0);

    // 2: full frame. byte5 = {11,11,10,~c=1,~z=0} = 8'hFA
    set_ptr(8'h00);
    i2c_start();
    send("rd_addr_ack", 8'hA5, 1'b1);
    check_sig("rd_busy", busy, 1'b1);
    recv("frame_b0", 8'h80, 1'b1);
    recv("frame_b1", 8'h7F, 1'b1);
    recv("frame_b2", 8'hA9, 1'b1);
    recv("frame_b3", 8'h7F, 1'b1);
    recv("frame_b4", 8'hC0, 1'b1);
    recv("frame_b5", 8'hFA, 1'b0);
    check_sig("busy_after_nack", busy, 1'b1);
    i2c_stop();
    check_sig("busy_after_stop", busy, 1'b0);

    // 3: wrong address
    i2c_start();
    send("wrong_addr_nack", 8'hA6, 1'b0);
    check_sig("wrong_addr_busy", busy, 1'b0);
    i2c_stop();

    // 4: pointer past the end
    set_ptr(8'h04);
    i2c_start();
    send("p4_addr", 8'hA5, 1'b1);
    recv("p4_b4", 8'hC0, 1'b1);
    recv("p4_b5", 8'hFA, 1'b1);
    recv("p4_b6", 8'hFF, 1'b1);
    recv("p4_b7", 8'hFF, 1'b0);
    i2c_stop();
    expect_v("p4_ptr_after", 32'd8);
    observe("p4_ptr_after", {24'd0, dut.pointer_r});

    // Pointer wraps 0xFF -> 0x00
    set_ptr(8'hFE);
    i2c_start();
    send("wrap_addr", 8'hA5, 1'b1);
    recv("wrap_fe", 8'hFF, 1'b1);
    recv("wrap_ff", 8'hFF, 1'b1);
    recv("wrap_00", 8'h80, 1'b0);
    i2c_stop();

    // 5: snapshot holds while inputs change mid-read
    stick_x = 8'h10; stick_y = 8'h33;
    set_ptr(8'h00);
    i2c_start();
    send("snap_addr", 8'hA5, 1'b1);
    recv("snap_b0", 8'h10, 1'b1);
    stick_x = 8'h20; stick_y = 8'h44;
    recv("snap_b1", 8'h33, 1'b0);
    i2c_stop();
    set_ptr(8'h00);
    i2c_start();
    send("snap2_addr", 8'hA5, 1'b1);
    recv("snap2_b0", 8'h20, 1'b0);
    i2c_stop();

    // 6a: repeated START mid-read (next MSB is 1 so SDA is free)
    stick_y = 8'h80;
    set_ptr(8'h00);
    i2c_start();
    send("rs_addr1", 8'hA5, 1'b1);
    recv("rs_b0", 8'h20, 1'b1);
    i2c_start();
    send("rs_addr2", 8'hA5, 1'b1);
    recv("rs_b1", 8'h80, 1'b0);
    i2c_stop();

    // 6b: reset while the target drives a 0 bit
    set_ptr(8'h00);
    i2c_start();
    send("rr_addr", 8'hA5, 1'b1);
    check_sig("rr_driving0", sda, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_sig("rr_sda_released", sda, 1'b1);
    check_sig("rr_busy", busy, 1'b0);
    @(negedge clk);
    check_sig("rr_init_done", init_done, 1'b0);
    expect_v("rr_ptr", 32'd0);
    observe("rr_ptr", {24'd0, dut.pointer_r});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    i2c_stop();
`ifdef NUNCHUCK_INIT_CHECK_EN
    post_rst = 8'hFF;
`else
    post_rst = 8'h20;
`endif
    i2c_start();
    send("post_rst_addr", 8'hA5, 1'b1);
    recv("post_rst_b0", post_rst, 1'b0);
    i2c_stop();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 100; i++) begin
      if (obs_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d observations and %0d expectations left, required 0 and 0",
               obs_q.size(), exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
